// File: rtl/pipe_pkg.sv
// ============================================================================
//  pipe_pkg : shared encodings for the generic pipeline stage register
//  Rev 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

   // 2'd3 is unused; the stage recovers from it to ST_EMPTY
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
//  pipe_stage_skid : valid/ready pipeline stage, optional 2-entry skid buffer,
//                    flush, bubble-zeroed control and saturating stall counter
//  Rev 1.0
// ============================================================================
`default_nettype none

module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 8,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic stall_now;
   assign stall_now = out_valid & ~out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_now && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         skid_state_t       state;
         skid_state_t       state_nx;
         logic [DATA_W-1:0] main_data;
         logic [DATA_W-1:0] skid_data;
         logic [CTRL_W-1:0] main_ctrl;
         logic [CTRL_W-1:0] skid_ctrl;
         logic              xfer_in;
         logic              xfer_out;
         logic              main_from_in;
         logic              main_from_skid;
         logic              main_clear;
         logic              skid_from_in;
         logic              skid_clear;

         // in_ready comes from state only, so out_ready never reaches it combinationally
         assign in_ready  = ~rst & ((state == ST_EMPTY) | (state == ST_ONE));
         assign out_valid = (state == ST_ONE) | (state == ST_FULL);
         assign out_data  = main_data;
         assign out_ctrl  = main_ctrl;
         assign xfer_in   = in_valid & in_ready & ~flush;
         assign xfer_out  = out_valid & out_ready;

         always_comb begin
            state_nx       = state;
            main_from_in   = 1'b0;
            main_from_skid = 1'b0;
            main_clear     = 1'b0;
            skid_from_in   = 1'b0;
            skid_clear     = 1'b0;
            case (state)
               ST_EMPTY: begin
                  if (xfer_in) begin
                     state_nx     = ST_ONE;
                     main_from_in = 1'b1;
                  end
               end
               ST_ONE: begin
                  if (xfer_in && xfer_out) begin
                     main_from_in = 1'b1;
                  end else if (xfer_in) begin
                     state_nx     = ST_FULL;
                     skid_from_in = 1'b1;
                  end else if (xfer_out) begin
                     state_nx   = ST_EMPTY;
                     main_clear = 1'b1;
                  end
               end
               ST_FULL: begin
                  if (xfer_out) begin
                     state_nx       = ST_ONE;
                     main_from_skid = 1'b1;
                     skid_clear     = 1'b1;
                  end
               end
               default: begin
                  state_nx   = ST_EMPTY;
                  main_clear = 1'b1;
                  skid_clear = 1'b1;
               end
            endcase
            if (flush) begin
               state_nx       = ST_EMPTY;
               main_from_in   = 1'b0;
               main_from_skid = 1'b0;
               skid_from_in   = 1'b0;
               main_clear     = 1'b1;
               skid_clear     = 1'b1;
            end
         end

         // Control is zeroed whenever an entry is vacated so a bubble carries no write enables
         always_ff @(posedge clk) begin
            if (rst) begin
               state     <= ST_EMPTY;
               main_data <= '0;
               main_ctrl <= '0;
               skid_data <= '0;
               skid_ctrl <= '0;
            end else begin
               state <= state_nx;
               if (main_from_in) begin
                  main_data <= in_data;
                  main_ctrl <= in_ctrl;
               end else if (main_from_skid) begin
                  main_data <= skid_data;
                  main_ctrl <= skid_ctrl;
               end else if (main_clear) begin
                  main_ctrl <= '0;
               end
               if (skid_from_in) begin
                  skid_data <= in_data;
                  skid_ctrl <= in_ctrl;
               end else if (skid_clear) begin
                  skid_ctrl <= '0;
               end
            end
         end
      end else begin : g_noskid
         logic              valid;
         logic [DATA_W-1:0] data;
         logic [CTRL_W-1:0] ctrl;
         logic              xfer_in;
         logic              xfer_out;

         assign in_ready  = ~rst & (out_ready | ~valid);
         assign out_valid = valid;
         assign out_data  = data;
         assign out_ctrl  = ctrl;
         assign xfer_in   = in_valid & in_ready & ~flush;
         assign xfer_out  = valid & out_ready;

         always_ff @(posedge clk) begin
            if (rst) begin
               valid <= 1'b0;
               data  <= '0;
               ctrl  <= '0;
            end else if (flush) begin
               valid <= 1'b0;
               ctrl  <= '0;
            end else if (xfer_in) begin
               valid <= 1'b1;
               data  <= in_data;
               ctrl  <= in_ctrl;
            end else if (xfer_out) begin
               valid <= 1'b0;
               ctrl  <= '0;
            end
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
//  tb_pipe_stage_skid : scoreboard bench for pipe_stage_skid (SKID=1, SKID=0,
//                       and a narrow-counter SKID=1 copy)
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

   logic        clk;
   logic        rst;
   logic        flush, in_valid, out_ready;
   logic [31:0] in_data;
   logic [7:0]  in_ctrl;
   logic        c_flush, c_in_valid, c_out_ready;
   logic [31:0] c_in_data;
   logic [7:0]  c_in_ctrl;

   logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
   logic [31:0] a_out_data, b_out_data, c_out_data;
   logic [7:0]  a_out_ctrl, b_out_ctrl, c_out_ctrl;
   logic [15:0] a_stall_cnt, c_stall_cnt;
   logic [3:0]  b_stall_cnt;

   logic [39:0] qa[$];
   logic [39:0] qc[$];
   int          stall_a, stall_b, stall_c;
   int          n_out_a, n_out_c;
   int          n_err, n_chk;

   pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_data(a_out_data), .out_ctrl(a_out_ctrl), .stall_cnt(a_stall_cnt));

   pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_b (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_data(b_out_data), .out_ctrl(b_out_ctrl), .stall_cnt(b_stall_cnt));

   pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_c (
      .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .in_ctrl(c_in_ctrl), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_data(c_out_data), .out_ctrl(c_out_ctrl), .stall_cnt(c_stall_cnt));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks all three instances against their queues, then advances the models by one cycle
   task automatic tick();
      logic a_rdy, a_val, c_rdy, c_val;
      #1;
      if (rst) begin
         chk("rst_in_ready_a", a_in_ready, 0);
         chk("rst_in_ready_c", c_in_ready, 0);
         qa.delete(); qc.delete();
         stall_a = 0; stall_b = 0; stall_c = 0;
      end else begin
         a_val = (qa.size() != 0);
         a_rdy = (qa.size() < 2);
         c_val = (qc.size() != 0);
         c_rdy = c_out_ready || (qc.size() == 0);
         chk("a_out_valid", a_out_valid, a_val);
         chk("b_out_valid", b_out_valid, a_val);
         chk("a_in_ready", a_in_ready, a_rdy);
         chk("b_in_ready", b_in_ready, a_rdy);
         chk("a_stall_cnt", a_stall_cnt, stall_a);
         chk("b_stall_cnt", b_stall_cnt, stall_b);
         chk("c_out_valid", c_out_valid, c_val);
         chk("c_in_ready", c_in_ready, c_rdy);
         chk("c_stall_cnt", c_stall_cnt, stall_c);
         if (a_val) begin
            chk("a_payload", {a_out_ctrl, a_out_data}, qa[0]);
            chk("b_payload", {b_out_ctrl, b_out_data}, qa[0]);
         end else begin
            chk("a_ctrl_bubble", a_out_ctrl, 0);
            chk("b_ctrl_bubble", b_out_ctrl, 0);
         end
         if (c_val) chk("c_payload", {c_out_ctrl, c_out_data}, qc[0]);
         else       chk("c_ctrl_bubble", c_out_ctrl, 0);

         if (a_val && !out_ready) begin
            if (stall_a != 65535) stall_a++;
            if (stall_b != 15)    stall_b++;
         end
         if (a_val && out_ready) begin
            void'(qa.pop_front());
            n_out_a++;
         end
         if (flush) qa.delete();
         else if (in_valid && a_rdy) qa.push_back({in_ctrl, in_data});

         if (c_val && !c_out_ready && stall_c != 65535) stall_c++;
         if (c_val && c_out_ready) begin
            void'(qc.pop_front());
            n_out_c++;
         end
         if (c_flush) qc.delete();
         else if (c_in_valid && c_rdy) qc.push_back({c_in_ctrl, c_in_data});
      end
      @(negedge clk);
   endtask

   initial begin
      n_err = 0; n_chk = 0; n_out_a = 0; n_out_c = 0;
      stall_a = 0; stall_b = 0; stall_c = 0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_ctrl = '0;
      c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = '0; c_in_ctrl = '0;

      // reset held two cycles, then idle
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("reset_out_valid", a_out_valid, 0);
      chk("reset_out_ctrl", a_out_ctrl, 0);
      chk("reset_out_data", a_out_data, 0);
      chk("reset_stall_cnt", a_stall_cnt, 0);
      chk("reset_in_ready", a_in_ready, 1);
      chk("reset_out_data_c", c_out_data, 0);
      tick();

      // back-to-back stream 1..8 with downstream always ready
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(i);
         in_ctrl  = 8'(i + 16);
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      chk("stream_count", n_out_a, 8);

      // fill to FULL with downstream stalled, offer a third word, then hold 20 more cycles
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hA5; in_ctrl = 8'h11;
      tick();
      in_data = 32'h5A; in_ctrl = 8'h22;
      tick();
      in_data = 32'h33; in_ctrl = 8'h33;
      tick();
      #1;
      chk("full_in_ready", a_in_ready, 0);
      chk("full_hold_data", a_out_data, 32'hA5);
      in_valid = 1'b0;
      repeat (20) tick();
      chk("stall_cnt_16", a_stall_cnt, 22);
      chk("stall_cnt_sat4", b_stall_cnt, 15);
      tick();
      chk("stall_cnt_sat4_hold", b_stall_cnt, 15);
      out_ready = 1'b1;
      repeat (3) tick();
      chk("drain_count", n_out_a, 10);
      chk("drain_empty", a_out_valid, 0);

      // flush while FULL, with a word offered in the flush cycle
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h01; in_ctrl = 8'h41;
      tick();
      in_data = 32'h02; in_ctrl = 8'h42;
      tick();
      flush = 1'b1; in_data = 32'h77; in_ctrl = 8'hFF;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", a_out_valid, 0);
      chk("flush_out_ctrl", a_out_ctrl, 0);
      out_ready = 1'b1;
      repeat (4) tick();
      chk("flush_no_emit", n_out_a, 10);

      // SKID=0 instance under random handshakes with occasional flush
      for (int i = 0; i < 10000; i++) begin
         c_in_valid  = 1'($urandom_range(0, 1));
         c_out_ready = 1'($urandom_range(0, 1));
         c_flush     = ($urandom_range(0, 63) == 0);
         c_in_data   = 32'($urandom);
         c_in_ctrl   = 8'($urandom);
         tick();
      end
      c_in_valid = 1'b0; c_flush = 1'b0; c_out_ready = 1'b1;
      repeat (3) tick();
      chk("random_drained", qc.size(), 0);
      chk("random_out_valid", c_out_valid, 0);
      chk("random_progress", (n_out_c > 1000), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
